// File: rtl/logic_gate_unit.sv
// Bitwise logic unit with a DEPTH-entry result FIFO and valid/ready handshakes on both sides.
// A request is evaluated on the edge it is accepted.
// The result, with its error bit, is written into the FIFO tail on that same edge.
// Optional feature: define LOGIC_GATE_UNIT_COUNT_EN to add the 16-bit result_cnt output.
// result_cnt counts pops and wraps from 65535 to 0.
module logic_gate_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_err
`ifdef LOGIC_GATE_UNIT_COUNT_EN
    ,
    output logic [15:0]      result_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    // Held low through reset so in_ready only rises on the first edge after release.
    logic             live_q;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] result;
    logic             result_err;

    // Decode the requested bitwise operation; OP=7 yields zero and flags an error.
    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (op)
            3'd0:    result = a & b;
            3'd1:    result = a | b;
            3'd2:    result = a ^ b;
            3'd3:    result = ~(a & b);
            3'd4:    result = ~(a | b);
            3'd5:    result = ~(a ^ b);
            3'd6:    result = ~a;
            default: result_err = 1'b1;
        endcase
    end

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = live_q && (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign y         = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_err   = out_valid & err_q[rd_ptr_q];

    // Occupancy next state: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and occupancy; reset discards every entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            err_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            count_q <= count_d;
            if (push) begin
                data_q[wr_ptr_q] <= result;
                err_q[wr_ptr_q]  <= result_err;
                // DEPTH is a power of two, so the pointer wraps naturally.
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef LOGIC_GATE_UNIT_COUNT_EN
    logic [15:0] cnt_q;

    // Count delivered results; the 16-bit register wraps to 0 after 65535.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign result_cnt = cnt_q;
`endif

endmodule
